// File: rtl/sum8_trio_power_pkg.sv
// Shared constants and helpers for the three-architecture 8-bit adder block.
package sum8_trio_power_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 32;

    // Widths of the per-architecture node vectors watched by the toggle counters
    localparam int unsigned NODE_W_RIZADO = 16;
    localparam int unsigned NODE_W_LOGICO = 24;
    localparam int unsigned NODE_W_LOOK   = 20;

    // Counter indices relative to CNT_BASE
    localparam int unsigned CNT_RIZADO = 0;
    localparam int unsigned CNT_LOGICO = 1;
    localparam int unsigned CNT_LOOK   = 2;

    // Internal carries c1..c3 of a 4-bit lookahead group, flat sum-of-products
    function automatic logic [2:0] grp_carry(input logic [3:0] g, input logic [3:0] p,
                                             input logic ci);
        logic [2:0] c;
        c[0] = g[0] | (p[0] & ci);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

endpackage

// File: rtl/sum8_toggle_counter.sv
// Counts bit transitions of a node vector between accepted operations.
module sum8_toggle_counter #(
    parameter int unsigned NODE_W = sum8_trio_power_pkg::NODE_W_LOGICO,
    parameter int unsigned CNT_W  = sum8_trio_power_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              clr_i,
    input  logic [NODE_W-1:0] nodes_i,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [NODE_W-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NODE_W-1:0] diff;
    logic [CNT_W-1:0]  pc;
    logic [CNT_W:0]    sum_ext;

    // Popcount of toggled nodes, saturating accumulate; clear overrides the count only
    always_comb begin
        diff = nodes_i ^ hist_q;
        pc   = '0;
        for (int i = 0; i < int'(NODE_W); i++) begin
            pc = pc + CNT_W'(diff[i]);
        end
        sum_ext = {1'b0, cnt_q} + {1'b0, pc};
        hist_d  = hist_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            hist_d = nodes_i;
            cnt_d  = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    // History and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sum8_trio_power.sv
// Registered 8-bit adder built three ways, with per-architecture toggle counters.
module sum8_trio_power #(
    parameter int unsigned WIDTH    = sum8_trio_power_pkg::WIDTH,
    parameter int unsigned CNT_W    = sum8_trio_power_pkg::CNT_W,
    parameter int unsigned CNT_BASE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] opr_a,
    input  logic [WIDTH-1:0] opr_b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] suma_rizado,
    output logic             carry_rizado,
    output logic [WIDTH-1:0] suma_logico,
    output logic             carry_logico,
    output logic [WIDTH-1:0] suma_look,
    output logic             carry_look,
    output logic             out_valid,
    output logic             mismatch,
    input  logic [1:0]       cnt_sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_data
);
    import sum8_trio_power_pkg::*;

    logic [WIDTH:0]   c_r, c_l, c_k;
    logic [WIDTH-1:0] s_r, s_l, s_k;
    logic [WIDTH-1:0] g, p;
    logic             gp0, gg0, gp1, gg1;

    logic [WIDTH:0] res_r_q, res_r_d, res_l_q, res_l_d, res_k_q, res_k_d;
    logic           out_valid_q, out_valid_d, mismatch_q, mismatch_d;

    logic [NODE_W_RIZADO-1:0] nodes_r;
    logic [NODE_W_LOGICO-1:0] nodes_l;
    logic [NODE_W_LOOK-1:0]   nodes_k;
    logic [CNT_W-1:0]         cnt_r, cnt_l, cnt_k;

    assign g = opr_a & opr_b;
    assign p = opr_a ^ opr_b;

    // Ripple-carry chain
    always_comb begin
        c_r[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            s_r[i]   = opr_a[i] ^ opr_b[i] ^ c_r[i];
            c_r[i+1] = (opr_a[i] & opr_b[i]) | (c_r[i] & (opr_a[i] ^ opr_b[i]));
        end
    end

    // Each carry expanded independently as a flat OR of generate/propagate products
    always_comb begin
        logic acc, prod;
        c_l[0] = cin;
        for (int i = 0; i < int'(WIDTH); i++) begin
            acc = 1'b0;
            for (int k = 0; k <= i; k++) begin
                prod = g[k];
                for (int m = k + 1; m <= i; m++) begin
                    prod = prod & p[m];
                end
                acc = acc | prod;
            end
            prod = cin;
            for (int m = 0; m <= i; m++) begin
                prod = prod & p[m];
            end
            c_l[i+1] = acc | prod;
        end
        s_l = p ^ c_l[WIDTH-1:0];
    end

    // Two 4-bit lookahead groups; group generates exclude the incoming carry
    always_comb begin
        gp0 = &p[3:0];
        gg0 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        gp1 = &p[7:4];
        gg1 = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
        c_k[0]   = cin;
        c_k[3:1] = grp_carry(g[3:0], p[3:0], cin);
        c_k[4]   = gg0 | (gp0 & cin);
        c_k[7:5] = grp_carry(g[7:4], p[7:4], c_k[4]);
        c_k[8]   = gg1 | (gp1 & c_k[4]);
        s_k      = p ^ c_k[7:0];
    end

    assign nodes_r = {s_r, c_r[WIDTH:1]};
    assign nodes_l = {s_l, g, p};
    assign nodes_k = {s_k, c_k[WIDTH:1], gp0, gg0, gp1, gg1};

    // Result load on accepted operands, hold otherwise
    always_comb begin
        res_r_d     = res_r_q;
        res_l_d     = res_l_q;
        res_k_d     = res_k_q;
        mismatch_d  = mismatch_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            res_r_d    = {c_r[WIDTH], s_r};
            res_l_d    = {c_l[WIDTH], s_l};
            res_k_d    = {c_k[WIDTH], s_k};
            mismatch_d = (res_r_d != res_l_d) || (res_r_d != res_k_d);
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r_q     <= '0;
            res_l_q     <= '0;
            res_k_q     <= '0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
        end else begin
            res_r_q     <= res_r_d;
            res_l_q     <= res_l_d;
            res_k_q     <= res_k_d;
            out_valid_q <= out_valid_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign {carry_rizado, suma_rizado} = res_r_q;
    assign {carry_logico, suma_logico} = res_l_q;
    assign {carry_look, suma_look}     = res_k_q;
    assign out_valid                   = out_valid_q;
    assign mismatch                    = mismatch_q;

    sum8_toggle_counter #(.NODE_W(NODE_W_RIZADO), .CNT_W(CNT_W)) u_cnt_rizado (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (in_valid),
        .clr_i   (cnt_clr),
        .nodes_i (nodes_r),
        .cnt_o   (cnt_r)
    );

    sum8_toggle_counter #(.NODE_W(NODE_W_LOGICO), .CNT_W(CNT_W)) u_cnt_logico (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (in_valid),
        .clr_i   (cnt_clr),
        .nodes_i (nodes_l),
        .cnt_o   (cnt_l)
    );

    sum8_toggle_counter #(.NODE_W(NODE_W_LOOK), .CNT_W(CNT_W)) u_cnt_look (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (in_valid),
        .clr_i   (cnt_clr),
        .nodes_i (nodes_k),
        .cnt_o   (cnt_k)
    );

    // Counter readback; unmapped selects return zero
    always_comb begin
        int unsigned sel_idx;
        sel_idx  = 32'(cnt_sel);
        cnt_data = '0;
        if (sel_idx == CNT_BASE + CNT_RIZADO) begin
            cnt_data = cnt_r;
        end else if (sel_idx == CNT_BASE + CNT_LOGICO) begin
            cnt_data = cnt_l;
        end else if (sel_idx == CNT_BASE + CNT_LOOK) begin
            cnt_data = cnt_k;
        end
    end

endmodule

// File: tb/tb_sum8_trio_power.sv
// Self-checking bench for sum8_trio_power: vector table, directed sequences, random stream.
module tb_sum8_trio_power;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  opr_a, opr_b;
    logic        cin, in_valid;
    logic [7:0]  suma_rizado, suma_logico, suma_look;
    logic        carry_rizado, carry_logico, carry_look;
    logic        out_valid, mismatch;
    logic [1:0]  cnt_sel;
    logic        cnt_clr;
    logic [31:0] cnt_data;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [8:0]       m_res;
    logic             m_ov;
    logic [23:0]      m_hist[3];
    longint unsigned  m_cnt[3];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [8:0] res;
    } vec_t;
    vec_t tbl[6];

    sum8_trio_power dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opr_a        (opr_a),
        .opr_b        (opr_b),
        .cin          (cin),
        .in_valid     (in_valid),
        .suma_rizado  (suma_rizado),
        .carry_rizado (carry_rizado),
        .suma_logico  (suma_logico),
        .carry_logico (carry_logico),
        .suma_look    (suma_look),
        .carry_look   (carry_look),
        .out_valid    (out_valid),
        .mismatch     (mismatch),
        .cnt_sel      (cnt_sel),
        .cnt_clr      (cnt_clr),
        .cnt_data     (cnt_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Node vectors derived arithmetically from the operand values
    function automatic logic [23:0] nodes_of(input int k, input logic [7:0] a,
                                             input logic [7:0] b, input logic ci);
        int unsigned s, m, t;
        logic [7:0] cv;
        logic pg0, gg0, pg1, gg1;
        s = int'(a) + int'(b) + int'(ci);
        for (int i = 0; i < 8; i++) begin
            m     = (32'd1 << (i + 1)) - 1;
            t     = (int'(a) & m) + (int'(b) & m) + int'(ci);
            cv[i] = t[i+1];
        end
        pg0 = ((int'(a ^ b) & 15) == 15);
        gg0 = ((int'(a) & 15) + (int'(b) & 15)) > 15;
        pg1 = ((int'(a ^ b) >> 4) == 15);
        gg1 = ((int'(a) >> 4) + (int'(b) >> 4)) > 15;
        case (k)
            0:       return {8'h00, s[7:0], cv};
            1:       return {s[7:0], a & b, a ^ b};
            default: return {4'h0, s[7:0], cv, pg0, gg0, pg1, gg1};
        endcase
    endfunction

    task automatic model_reset();
        m_res = '0;
        m_ov  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            m_hist[k] = '0;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic model_edge(input logic [7:0] a, input logic [7:0] b, input logic ci,
                              input logic v, input logic clr);
        logic [23:0] n;
        m_ov = v;
        if (v) begin
            m_res = 9'(int'(a) + int'(b) + int'(ci));
            for (int k = 0; k < 3; k++) begin
                n = nodes_of(k, a, b, ci);
                m_cnt[k] = m_cnt[k] + longint'($countones(n ^ m_hist[k]));
                if (m_cnt[k] > 64'hFFFF_FFFF) m_cnt[k] = 64'hFFFF_FFFF;
                m_hist[k] = n;
            end
        end
        if (clr) begin
            for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        end
    endtask

    // Drive one cycle; checks happen at the following falling edge
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic v, input logic clr);
        opr_a    = a;
        opr_b    = b;
        cin      = ci;
        in_valid = v;
        cnt_clr  = clr;
        @(posedge clk);
        model_edge(a, b, ci, v, clr);
        @(negedge clk);
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic read_cnt(input logic [1:0] sel, output logic [31:0] val);
        cnt_sel = sel;
        #1;
        val = cnt_data;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] v;
        chk({tag, " rizado"}, 64'({carry_rizado, suma_rizado}), 64'(m_res));
        chk({tag, " logico"}, 64'({carry_logico, suma_logico}), 64'(m_res));
        chk({tag, " look"}, 64'({carry_look, suma_look}), 64'(m_res));
        chk({tag, " out_valid"}, 64'(out_valid), 64'(m_ov));
        chk({tag, " mismatch"}, 64'(mismatch), 64'd0);
        for (int k = 0; k < 4; k++) begin
            read_cnt(2'(k), v);
            chk($sformatf("%s cnt%0d", tag, k), 64'(v), (k == 3) ? 64'd0 : m_cnt[k]);
        end
    endtask

    initial begin
        logic [31:0] v, prev;
        logic [7:0]  ra, rb;
        int unsigned dummy;

        tbl[0] = '{a: 8'h24, b: 8'h81, ci: 1'b0, res: 9'h0A5};
        tbl[1] = '{a: 8'h00, b: 8'h00, ci: 1'b0, res: 9'h000};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, res: 9'h1FF};
        tbl[3] = '{a: 8'h0F, b: 8'h01, ci: 1'b0, res: 9'h010};
        tbl[4] = '{a: 8'h00, b: 8'hFF, ci: 1'b1, res: 9'h100};
        tbl[5] = '{a: 8'h7F, b: 8'h80, ci: 1'b1, res: 9'h100};

        rst_n    = 1'b0;
        opr_a    = '0;
        opr_b    = '0;
        cin      = 1'b0;
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        cnt_sel  = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Counts from zero history
        step(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        check_all("ff01");
        chk("ff01 res", 64'({carry_rizado, suma_rizado}), 64'h100);
        read_cnt(2'd0, v); chk("ff01 cnt rizado", 64'(v), 64'd8);
        read_cnt(2'd1, v); chk("ff01 cnt logico", 64'(v), 64'd8);
        read_cnt(2'd2, v); chk("ff01 cnt look", 64'(v), 64'd10);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b1, 1'b0);
            chk($sformatf("tbl%0d res", i), 64'({carry_look, suma_look}), 64'(tbl[i].res));
            check_all($sformatf("tbl%0d", i));
        end

        // Idle cycles hold everything
        for (int i = 0; i < 3; i++) begin
            step(8'h55, 8'h33, 1'b1, 1'b0, 1'b0);
            chk("idle res", 64'({carry_logico, suma_logico}), 64'h100);
            check_all("idle");
        end

        // Random stream
        dummy = $urandom(10);
        prev  = '0;
        for (int i = 0; i < 5000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            read_cnt(2'(i % 3), prev);
            step(ra, rb, 1'b0, 1'b1, 1'b0);
            chk("rnd rizado", 64'({carry_rizado, suma_rizado}), 64'(int'(ra) + int'(rb)));
            chk("rnd logico", 64'({carry_logico, suma_logico}), 64'(int'(ra) + int'(rb)));
            chk("rnd look", 64'({carry_look, suma_look}), 64'(int'(ra) + int'(rb)));
            chk("rnd mismatch", 64'(mismatch), 64'd0);
            read_cnt(2'(i % 3), v);
            chk("rnd cnt model", 64'(v), m_cnt[i % 3]);
            if (v < prev) chk("rnd cnt monotonic", 64'(v), 64'(prev));
        end

        // Clear without and with a coincident operation
        step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check_all("clr");
        step(8'h3C, 8'hA7, 1'b1, 1'b1, 1'b0);
        check_all("post clr op");
        step(8'hC3, 8'h5A, 1'b0, 1'b1, 1'b1);
        check_all("clr wins");
        step(8'h12, 8'h34, 1'b1, 1'b1, 1'b0);
        check_all("after clr wins");

        // Asynchronous reset between edges
        step(8'h99, 8'h66, 1'b1, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("mid reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        step(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        check_all("post reset");
        read_cnt(2'd2, v); chk("post reset cnt look", 64'(v), 64'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
